pipe_stage_hs: RTL and testbench

Parametrised pipeline stage register that replaces the fixed per-boundary pipe registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries an arbitrary-width payload under a valid/ready handshake, supports stall (back-pressure), flush (bubble insertion) and an optional skid slot for full throughput with a registered `in_ready`. It sits between any two pipeline stages; the core instantiates one per boundary with the concatenated stage bundle as payload.

---
 rtl/pipe_stage_hs_pkg.sv | 17 +
 rtl/pipe_slot.sv | 27 ++
 rtl/pipe_stage_hs.sv | 115 +++++++++++
 tb/tb_pipe_stage_hs.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_hs_pkg.sv
// Shared pipeline definitions: NOP word bit and occupancy/state encoding.
// Imported by every pipe stage register and its slots.
package pipe_stage_hs_pkg;

  localparam logic NOP_BIT = 1'b0;

  localparam logic [1:0] OCC_EMPTY     = 2'd0;
  localparam logic [1:0] OCC_FULL      = 2'd1;
  localparam logic [1:0] OCC_SKID_FULL = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY     = OCC_EMPTY,
    ST_FULL      = OCC_FULL,
    ST_SKID_FULL = OCC_SKID_FULL
  } state_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit plus payload register.
// Clearing zeroes the payload so a vacated slot always reads as NOP.
module pipe_slot
  import pipe_stage_hs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             sync_rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (sync_rst || clr) begin
      valid <= 1'b0;
      q     <= {WIDTH{NOP_BIT}};
    end else if (ld) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// Generic valid/ready pipeline stage register with flush and optional
// skid entry; one instance sits on each pipeline boundary.
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter bit SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             sync_rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  state_e state, state_n;

  logic             main_v;
  logic             skid_v;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] main_d;
  logic             main_ld, main_clr;
  logic             skid_ld, skid_clr;
  logic             in_xfer, out_xfer;

  assign out_valid = main_v;
  assign occupancy = state;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = main_v & out_ready;

  always_ff @(posedge clk) begin
    if (sync_rst) state <= ST_EMPTY;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    main_d   = in_data;
    main_ld  = 1'b0;
    main_clr = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    if (flush) begin
      state_n  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_ld = 1'b1;
            state_n = ST_FULL;
          end
        end
        ST_FULL: begin
          unique case (1'b1)
            in_xfer & out_xfer: main_ld = 1'b1;
            in_xfer & ~out_xfer: begin
              skid_ld = 1'b1;
              state_n = ST_SKID_FULL;
            end
            ~in_xfer & out_xfer: begin
              main_clr = 1'b1;
              state_n  = ST_EMPTY;
            end
            default: ;
          endcase
        end
        ST_SKID_FULL: begin
          if (out_xfer) begin
            main_d   = skid_q;
            main_ld  = 1'b1;
            skid_clr = 1'b1;
            state_n  = ST_FULL;
          end
        end
        default: state_n = ST_EMPTY;
      endcase
    end
  end

  pipe_slot #(.WIDTH(WIDTH)) u_main (
    .clk      (clk),
    .sync_rst (sync_rst),
    .clr      (main_clr),
    .ld       (main_ld),
    .d        (main_d),
    .valid    (main_v),
    .q        (out_data)
  );

  // With a skid entry, ready comes straight from the skid valid flop.
  if (SKID) begin : g_skid
    pipe_slot #(.WIDTH(WIDTH)) u_skid (
      .clk      (clk),
      .sync_rst (sync_rst),
      .clr      (skid_clr),
      .ld       (skid_ld),
      .d        (in_data),
      .valid    (skid_v),
      .q        (skid_q)
    );
    assign in_ready = ~skid_v & ~flush & ~sync_rst;
  end else begin : g_single
    assign skid_v   = 1'b0;
    assign skid_q   = {WIDTH{NOP_BIT}};
    assign in_ready = (~main_v | out_ready) & ~flush & ~sync_rst;
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: directed table plus random traffic on four
// configurations, each tracked by a queue-based reference model.
module tb_pipe_stage_hs;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, flush, iv, ordy;
  logic [96:0] din;

  logic         ov  [N];
  logic         ir  [N];
  logic [1:0]   occ [N];
  logic [127:0] od  [N];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = (g == 2) ? 1 : (g == 3) ? 97 : 32;
    localparam bit S = (g == 0) || (g == 2);

    logic [W-1:0] od_w;
    logic         ov_w, ir_w;
    logic [1:0]   occ_w;
    logic [W-1:0] q [$];

    pipe_stage_hs #(.WIDTH(W), .SKID(S)) u_dut (
      .clk       (clk),
      .sync_rst  (rst),
      .flush     (flush),
      .in_valid  (iv),
      .in_ready  (ir_w),
      .in_data   (din[W-1:0]),
      .out_valid (ov_w),
      .out_ready (ordy),
      .out_data  (od_w),
      .occupancy (occ_w)
    );

    assign ov[g]  = ov_w;
    assign ir[g]  = ir_w;
    assign occ[g] = occ_w;
    assign od[g]  = 128'(od_w);

    // Model: FIFO of capacity 2 (skid) or 1 (single), emptied by reset/flush.
    always @(negedge clk) begin
      logic         e_ir;
      logic [127:0] e_od;
      int           cap;
      cap  = S ? 2 : 1;
      e_ir = !rst && !flush &&
             (q.size() < cap || (!S && ordy));
      e_od = (q.size() > 0) ? 128'(q[0]) : 128'(0);
      if (chk_en) begin
        chk($sformatf("m%0d out_valid", g), 128'(ov_w), 128'(q.size() > 0));
        chk($sformatf("m%0d out_data", g), 128'(od_w), e_od);
        chk($sformatf("m%0d occupancy", g), 128'(occ_w), 128'(q.size()));
        chk($sformatf("m%0d in_ready", g), 128'(ir_w), 128'(e_ir));
      end
      if (rst || flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (iv && e_ir) q.push_back(din[W-1:0]);
      end
    end
  end

  typedef struct {
    bit          rst;
    bit          fl;
    bit          iv;
    logic [31:0] d;
    bit          ordy;
    bit          e_ov;
    logic [31:0] e_od;
    logic [1:0]  e_occ;
    bit          e_ir;
  } vec_t;

  vec_t tv [18];

  initial begin
    tv[0]  = '{1, 0, 1, 32'hDEADBEEF, 1, 0, 32'h0, 2'd0, 0};
    tv[1]  = '{1, 0, 1, 32'hDEADBEEF, 1, 0, 32'h0, 2'd0, 0};
    tv[2]  = '{0, 0, 1, 32'hA, 0, 0, 32'h0, 2'd0, 1};
    tv[3]  = '{0, 0, 1, 32'hB, 0, 1, 32'hA, 2'd1, 1};
    tv[4]  = '{0, 0, 1, 32'hC, 0, 1, 32'hA, 2'd2, 0};
    tv[5]  = '{0, 0, 0, 32'h0, 1, 1, 32'hA, 2'd2, 0};
    tv[6]  = '{0, 0, 0, 32'h0, 1, 1, 32'hB, 2'd1, 1};
    tv[7]  = '{0, 0, 1, 32'hA, 0, 0, 32'h0, 2'd0, 1};
    tv[8]  = '{0, 0, 1, 32'hB, 0, 1, 32'hA, 2'd1, 1};
    tv[9]  = '{0, 1, 1, 32'hC, 0, 1, 32'hA, 2'd2, 0};
    tv[10] = '{0, 0, 0, 32'h0, 1, 0, 32'h0, 2'd0, 1};
    tv[11] = '{0, 0, 1, 32'h5, 1, 0, 32'h0, 2'd0, 1};
    tv[12] = '{0, 0, 0, 32'h0, 1, 1, 32'h5, 2'd1, 1};
    tv[13] = '{0, 0, 0, 32'h0, 0, 0, 32'h0, 2'd0, 1};
    tv[14] = '{0, 0, 1, 32'h6, 0, 0, 32'h0, 2'd0, 1};
    tv[15] = '{0, 0, 1, 32'h7, 0, 1, 32'h6, 2'd1, 1};
    tv[16] = '{1, 0, 1, 32'h8, 0, 1, 32'h6, 2'd2, 0};
    tv[17] = '{0, 0, 0, 32'h0, 1, 0, 32'h0, 2'd0, 1};

    rst   = 1'b1;
    flush = 1'b0;
    iv    = 1'b1;
    din   = 97'hDEADBEEF;
    ordy  = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;

    for (int i = 0; i < 18; i++) begin
      rst   = tv[i].rst;
      flush = tv[i].fl;
      iv    = tv[i].iv;
      din   = 97'(tv[i].d);
      ordy  = tv[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d out_valid", i), 128'(ov[0]), 128'(tv[i].e_ov));
      chk($sformatf("vec%0d out_data", i), od[0], 128'(tv[i].e_od));
      chk($sformatf("vec%0d occupancy", i), 128'(occ[0]), 128'(tv[i].e_occ));
      chk($sformatf("vec%0d in_ready", i), 128'(ir[0]), 128'(tv[i].e_ir));
      @(posedge clk);
      #1;
    end

    // Back-to-back stream 0x1..0x10, one output per cycle.
    for (int i = 0; i < 18; i++) begin
      rst   = 1'b0;
      flush = 1'b0;
      iv    = (i < 16);
      din   = 97'(i + 1);
      ordy  = 1'b1;
      @(negedge clk);
      chk($sformatf("stream%0d out_valid", i), 128'(ov[0]),
          128'(i >= 1 && i <= 16));
      chk($sformatf("stream%0d out_data", i), od[0],
          (i >= 1 && i <= 16) ? 128'(i) : 128'(0));
      @(posedge clk);
      #1;
    end

    // Constant valid with random ready, no flush.
    for (int i = 0; i < 200; i++) begin
      iv   = 1'b1;
      ordy = $urandom_range(0, 1) != 0;
      din  = 97'({$urandom, $urandom, $urandom, $urandom});
      @(negedge clk);
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 10000; i++) begin
      rst   = $urandom_range(0, 499) == 0;
      flush = $urandom_range(0, 31) == 0;
      iv    = $urandom_range(0, 3) != 0;
      ordy  = $urandom_range(0, 2) != 0;
      din   = 97'({$urandom, $urandom, $urandom, $urandom});
      @(negedge clk);
      @(posedge clk);
      #1;
    end

    rst   = 1'b0;
    flush = 1'b0;
    iv    = 1'b0;
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
